alu_result_monitor: RTL
=======================

# alu_result_monitor

Self-checking consumer for the 8-bit ALU. The ALU cycles its operation select 0→7 every clock from reset. This block mirrors that select sequence, recomputes each expected result and carry from the same operands, and compares them against the ALU outputs. It reports mismatches, keeps saturating error and sweep counters, and captures the first failing operation. It sits beside the ALU in the integration bench and in silicon debug builds.

## Interface
- ERR_CNT_W, 16, width of `err_count` (saturating)
- SWEEP_CNT_W, 16, width of `sweep_count` (saturating)

- clk  in  1  rising-edge clock, same as the ALU
- reset_n  in  1  asynchronous, active-low reset, same assertion as the ALU
- enable  in  1  level; checking runs while high
- clear  in  1  synchronous; zeroes all status and returns to IDLE
- a, b  in  8 each  operands driven to the ALU, same cycle
- alu_out  in  8  registered ALU result; valid one cycle after its op cycle
- carry_out  in  1  ALU carry flag; combinational, valid in the op cycle
- phase  out  3  mirrored op select
- mismatch  out  1  one-cycle pulse per failing op
- err_sticky  out  1  set on first mismatch
- err_count  out  ERR_CNT_W  mismatches seen
- sweep_count  out  SWEEP_CNT_W  completed, checked op-7 compares
- first_err_op  out  3  op code of the first mismatch
- first_err_got, first_err_exp  out  8 each  captured result and expected result of the first mismatch
- busy  out  1  high in PRIME or CHECK

## Operation
- `phase` resets to 0 and increments every clock with wrap 7→0, independent of `enable`, `clear` and state. It equals the ALU select in the same cycle.
- Expected result for the current `phase`:
  - 0 ADD: {0,a}+{0,b}; carry = bit 8.
  - 1 SUB: (a−b) mod 256; carry = (a<b).
  - 2 AND, 3 OR, 4 XOR, 5 XNOR, 6 NAND, 7 NOR: carry = 0.
- Pipeline stage, every cycle: register `exp_q`, `op_q` = `phase`, and `cerr_q` = (`carry_out` != expected carry).
- Compare, in CHECK only: `fail` = (`alu_out` != `exp_q`) | `cerr_q`. A result error and a carry error from the same op produce one event.
- States:
  - IDLE: go to PRIME when `enable`=1.
  - PRIME: one cycle to fill `exp_q`; no compare; go to CHECK.
  - CHECK: compare every cycle; go to IDLE when `enable`=0, with no compare on the exit edge.
  - HALT: macro only; see Configuration.
- On `fail`:
  - `mismatch` pulses.
  - `err_count` increments, saturating at all-ones.
  - If `err_sticky`=0: set it, and capture `op_q`, `alu_out` and `exp_q`.
- On a CHECK compare of `op_q`=7 with no fail: `sweep_count` increments, saturating.
- `clear`=1: zero all status, state→IDLE. `clear` wins over a simultaneous `fail`; that event is dropped.
- `enable` dropped mid-sweep: counters and captures hold. Re-enable goes through PRIME again.

## Timing
- Reset values: `phase`=0, state IDLE, `busy`=0, `mismatch`=0, `err_sticky`=0, both counters 0, all captures 0.
- Op cycle t:
  - compare in cycle t+1;
  - `mismatch`, counters and captures visible in cycle t+2.
- `enable` high at edge e:
  - PRIME in cycle e+1;
  - first compare in cycle e+2, which checks the op of cycle e+1.
- `reset_n` low mid-CHECK: all registers take reset values immediately, without a clock.

## Configuration
- `ALU_MON_HALT_ON_ERR_EN` defined:
  - the first `fail` moves CHECK→HALT;
  - HALT does no compares, freezes counters and captures, and drives `busy`=0;
  - HALT exits only via `clear` (→IDLE) or reset.
- Undefined: HALT does not exist, and checking continues through errors.

## Test plan
- Reset: all outputs at reset values; `phase` reads 0,1,…,7,0 on consecutive cycles.
- Correct ALU, a=0x3C, b=0xA5, 3 sweeps:
  - expected values 0xE1/c0, 0x97/c1, 0x24, 0xBD, 0x99, 0x66, 0xDB, 0x42;
  - `err_count`=0 and `sweep_count`=3.
- a=0xFF, b=0x01, ADD op: expects 0x00 with carry 1; forcing `carry_out`=0 gives one `mismatch` and `first_err_op`=0.
- Flip `alu_out` bit 0 on the AND result (a=0x3C, b=0xA5):
  - `err_count`=1 and `first_err_op`=2;
  - `first_err_got`=0x25, `first_err_exp`=0x24;
  - a second fault in a later cycle leaves the captures unchanged.
- ERR_CNT_W=2 with continuous faults: `err_count` saturates at 3. With the macro defined, the state instead goes to HALT after the first fault and `err_count` stays at 1.
- `clear` coincident with a fault: no `mismatch` pulse and all status reads 0. `reset_n` pulsed mid-CHECK: outputs return to reset values asynchronously.

Source files
------------

// File: rtl/alu_result_monitor.sv
// -----------------------------------------------------------------------------
// alu_result_monitor
//
// Self-checking consumer placed beside the 8-bit ALU. It mirrors the ALU's
// free-running op select (0..7, one step per clock), recomputes the expected
// result and carry from the same operands, and compares them against the ALU
// outputs one cycle later. Mismatches are reported as a one-cycle pulse,
// counted in a saturating error counter, and the first failing op is captured.
// Clean op-7 compares are counted as completed sweeps.
//
// Optional build macro: ALU_MON_HALT_ON_ERR_EN
//   When defined, the first failing compare parks the monitor in HALT, which
//   freezes all status until clear or reset. When undefined, HALT does not
//   exist and checking simply continues through errors.
// -----------------------------------------------------------------------------
module alu_result_monitor #(
  parameter int ERR_CNT_W   = 16,
  parameter int SWEEP_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   clear,
  input  logic [7:0]             a,
  input  logic [7:0]             b,
  input  logic [7:0]             alu_out,
  input  logic                   carry_out,
  output logic [2:0]             phase,
  output logic                   mismatch,
  output logic                   err_sticky,
  output logic [ERR_CNT_W-1:0]   err_count,
  output logic [SWEEP_CNT_W-1:0] sweep_count,
  output logic [2:0]             first_err_op,
  output logic [7:0]             first_err_got,
  output logic [7:0]             first_err_exp,
  output logic                   busy
);

  // ---------------------------------------------------------------------------
  // Types and constants
  // ---------------------------------------------------------------------------
`ifdef ALU_MON_HALT_ON_ERR_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_CHECK = 2'd2,
    ST_HALT  = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_CHECK = 2'd2
  } state_e;
`endif

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NAND = 3'd6,
    OP_NOR  = 3'd7
  } op_e;

  localparam logic [ERR_CNT_W-1:0]   ERR_MAX   = '1;
  localparam logic [SWEEP_CNT_W-1:0] SWEEP_MAX = '1;
  localparam logic [ERR_CNT_W-1:0]   ERR_ONE   = ERR_CNT_W'(1);
  localparam logic [SWEEP_CNT_W-1:0] SWEEP_ONE = SWEEP_CNT_W'(1);

  // Expected {carry, result} of one ALU op on the given operands.
  function automatic logic [8:0] calc_expected(input logic [2:0] op,
                                               input logic [7:0] x,
                                               input logic [7:0] y);
    logic [8:0] sum;
    logic [8:0] res;
    sum = {1'b0, x} + {1'b0, y};
    res = 9'd0;
    case (op_e'(op))
      OP_ADD:  res = sum;
      OP_SUB:  res = {(x < y), x - y};
      OP_AND:  res = {1'b0, x & y};
      OP_OR:   res = {1'b0, x | y};
      OP_XOR:  res = {1'b0, x ^ y};
      OP_XNOR: res = {1'b0, ~(x ^ y)};
      OP_NAND: res = {1'b0, ~(x & y)};
      OP_NOR:  res = {1'b0, ~(x | y)};
      default: res = 9'd0;
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [2:0]             phase_q;
  logic [7:0]             exp_q;
  logic [2:0]             op_q;
  logic                   cerr_q;
  state_e                 state_q, state_d;
  logic                   mismatch_q, mismatch_d;
  logic                   sticky_q, sticky_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [SWEEP_CNT_W-1:0] sweep_cnt_q, sweep_cnt_d;
  logic [2:0]             fe_op_q, fe_op_d;
  logic [7:0]             fe_got_q, fe_got_d;
  logic [7:0]             fe_exp_q, fe_exp_d;

  // Combinational helpers
  logic [8:0] exp_now;
  logic       compare;
  logic       fail;

  // Expected result and carry for the op the ALU is executing this cycle.
  always_comb begin
    exp_now = calc_expected(phase_q, a, b);
  end

  // Phase mirror and one-stage pipeline aligning expectations with alu_out.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, matching real hardware ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= 3'd0;
      exp_q   <= 8'd0;
      op_q    <= 3'd0;
      cerr_q  <= 1'b0;
    end else begin
      phase_q <= phase_q + 3'd1;
      exp_q   <= exp_now[7:0];
      op_q    <= phase_q;
      cerr_q  <= (carry_out != exp_now[8]);
    end
  end

  // A compare happens only in CHECK with enable still high; the exit edge
  // (enable low) is not checked. Result and carry errors merge into one event.
  assign compare = (state_q == ST_CHECK) && enable;
  assign fail    = compare && ((alu_out != exp_q) || cerr_q);

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------

  // Next-state logic: IDLE -> PRIME -> CHECK, back to IDLE on enable low.
  // NOTE: every always_comb output gets a default first so no path through the
  // case can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_PRIME;
      end
      ST_PRIME: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end
`ifdef ALU_MON_HALT_ON_ERR_EN
        else if (fail) begin
          state_d = ST_HALT;
        end
`endif
      end
`ifdef ALU_MON_HALT_ON_ERR_EN
      ST_HALT: begin
        state_d = ST_HALT;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    if (clear) state_d = ST_IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Status: mismatch pulse, saturating counters, first-error capture
  // ---------------------------------------------------------------------------

  // Status next-state; clear overrides everything, dropping a coincident fail.
  always_comb begin
    mismatch_d  = fail;
    sticky_d    = sticky_q;
    err_cnt_d   = err_cnt_q;
    sweep_cnt_d = sweep_cnt_q;
    fe_op_d     = fe_op_q;
    fe_got_d    = fe_got_q;
    fe_exp_d    = fe_exp_q;

    if (fail) begin
      if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + ERR_ONE;
      if (!sticky_q) begin
        sticky_d = 1'b1;
        fe_op_d  = op_q;
        fe_got_d = alu_out;
        fe_exp_d = exp_q;
      end
    end else if (compare && (op_q == 3'd7)) begin
      if (sweep_cnt_q != SWEEP_MAX) sweep_cnt_d = sweep_cnt_q + SWEEP_ONE;
    end

    if (clear) begin
      mismatch_d  = 1'b0;
      sticky_d    = 1'b0;
      err_cnt_d   = '0;
      sweep_cnt_d = '0;
      fe_op_d     = 3'd0;
      fe_got_d    = 8'd0;
      fe_exp_d    = 8'd0;
    end
  end

  // Status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mismatch_q  <= 1'b0;
      sticky_q    <= 1'b0;
      err_cnt_q   <= '0;
      sweep_cnt_q <= '0;
      fe_op_q     <= 3'd0;
      fe_got_q    <= 8'd0;
      fe_exp_q    <= 8'd0;
    end else begin
      mismatch_q  <= mismatch_d;
      sticky_q    <= sticky_d;
      err_cnt_q   <= err_cnt_d;
      sweep_cnt_q <= sweep_cnt_d;
      fe_op_q     <= fe_op_d;
      fe_got_q    <= fe_got_d;
      fe_exp_q    <= fe_exp_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign phase         = phase_q;
  assign mismatch      = mismatch_q;
  assign err_sticky    = sticky_q;
  assign err_count     = err_cnt_q;
  assign sweep_count   = sweep_cnt_q;
  assign first_err_op  = fe_op_q;
  assign first_err_got = fe_got_q;
  assign first_err_exp = fe_exp_q;
  assign busy          = (state_q == ST_PRIME) || (state_q == ST_CHECK);

endmodule
